// File: rtl/forward_arbiter.sv
// forward_arbiter: request-path arbiter for one slave port of the crossbar.
// It picks among the master request FIFOs whose head beat targets this slave
// and pushes the winning beat into the slave request FIFO.
// Arbitration is round-robin per packet. Once a multi-beat packet has started,
// the grant stays on that master until the packet's last beat.
// Optional build macro FORWARD_ARB_STATS_EN adds per-master completed-packet
// counters on the output packet_count. Each counter is 16 bits and saturates.
module forward_arbiter #(
  parameter int masters           = 2,
  parameter int slaves            = 2,
  parameter int i_am_slave_number = 0
) (
  input  logic                                        ACLK,
  input  logic                                        ARESETn,
  input  logic [masters-1:0]                          master_fifo_empty,
  input  logic [masters-1:0][$clog2(slaves)-1:0]      master_slave_dest,
  input  logic [masters-1:0]                          master_last,
  input  logic                                        slave_fifo_full,
  output logic                                        push_to_fifo,
  output logic [masters-1:0]                          pop_master_vec,
  output logic [$clog2(masters)-1:0]                  grant_master_number,
`ifdef FORWARD_ARB_STATS_EN
  output logic [masters-1:0][15:0]                    packet_count,
`endif
  output logic                                        locked
);

  localparam int MW = $clog2(masters);
  localparam int DW = $clog2(slaves);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   rr_q, rr_d;
  logic [MW-1:0]   lock_q, lock_d;

  logic [masters-1:0] req;
  logic [MW-1:0]      win;
  logic               any_req;
  logic [MW:0]        cand;
  logic               push;
  logic [MW-1:0]      grant;

  // Wrap to 0 after the last master; this also works when masters is not a power of two.
  function automatic logic [MW-1:0] rr_inc(input logic [MW-1:0] p);
    return (p == MW'(masters - 1)) ? '0 : p + MW'(1);
  endfunction

  // A master requests this slave when its FIFO is non-empty and its head beat targets this slave.
  always_comb begin
    for (int i = 0; i < masters; i++)
      req[i] = ~master_fifo_empty[i] & (master_slave_dest[i] == DW'(i_am_slave_number));
  end

  // Round-robin search that starts at rr_q. When nothing requests, win falls back to rr_q.
  always_comb begin
    win     = rr_q;
    any_req = 1'b0;
    cand    = '0;
    for (int k = 0; k < masters; k++) begin
      cand = {1'b0, rr_q} + (MW+1)'(k);
      if (cand >= (MW+1)'(masters)) cand = cand - (MW+1)'(masters);
      if (!any_req && req[cand[MW-1:0]]) begin
        any_req = 1'b1;
        win     = cand[MW-1:0];
      end
    end
  end

  // Next-state logic plus the raw push and grant. They are granted with zero latency in the same cycle.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    push    = 1'b0;
    grant   = rr_q;
    case (state_q)
      IDLE: begin
        grant = win;
        if (any_req && !slave_fifo_full) begin
          push = 1'b1;
          if (master_last[win]) rr_d = rr_inc(win);
          else begin
            state_d = LOCKED;
            lock_d  = win;
          end
        end
      end
      LOCKED: begin
        // While locked, other masters are ignored. A missing or misrouted head just stalls the packet.
        grant = lock_q;
        push  = req[lock_q] & ~slave_fifo_full;
        if (push && master_last[lock_q]) begin
          state_d = IDLE;
          rr_d    = rr_inc(lock_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state register. Reset drops any lock in progress.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      rr_q    <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
    end
  end

  // Outputs are forced to zero while reset is asserted. Requests may still be present during reset.
  always_comb begin
    push_to_fifo        = push & ARESETn;
    grant_master_number = ARESETn ? grant : '0;
    locked              = (state_q == LOCKED);
    for (int i = 0; i < masters; i++)
      pop_master_vec[i] = push_to_fifo & (grant_master_number == MW'(i));
  end

`ifdef FORWARD_ARB_STATS_EN
  logic [masters-1:0][15:0] packet_count_q;

  // Count completed packets per master. A packet completes on a push of a last beat; counters saturate.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      packet_count_q <= '0;
    end else if (push_to_fifo && master_last[grant_master_number]) begin
      if (packet_count_q[grant_master_number] != 16'hFFFF)
        packet_count_q[grant_master_number] <= packet_count_q[grant_master_number] + 16'd1;
    end
  end

  assign packet_count = packet_count_q;
`endif

endmodule

// File: doc/forward_arbiter.md
Name: forward_arbiter

Overview:
- One instance per slave port. Arbitrates among the masters' request FIFOs whose head entry targets this slave, and pushes the winner's beat into this slave's request FIFO.
- Arbitration is round-robin per packet. Once a multi-beat packet starts, the grant is locked to that master until its last beat.
- Counterpart of the per-master return-path arbiter. Together they form the request and return halves of the crossbar.

Parameters:
- masters, 2, number of master request FIFOs (>=2)
- slaves, 2, number of slave ports (>=2); sets the width of the destination field
- i_am_slave_number, 0, index of this slave; a master's destination is compared against it

Ports:
- ACLK  input  1  clock; all state updates on rising edge
- ARESETn  input  1  asynchronous active-low reset; asserting clears all state immediately, deassertion is synchronous to ACLK
- master_fifo_empty  input  1 x [0:masters-1]  request FIFO empty flag per master
- master_slave_dest  input  $clog2(slaves) x [0:masters-1]  destination slave of each master FIFO head entry
- master_last  input  1 x [0:masters-1]  head entry is the last beat of its packet
- slave_fifo_full  input  1  this slave's request FIFO is full
- push_to_fifo  output  1  push one beat into the slave FIFO this cycle
- pop_master_vec  output  masters  one-hot pop strobe to the granted master FIFO; equals push_to_fifo AND grant decode
- grant_master_number  output  $clog2(masters)  master whose head drives the slave FIFO write-data mux
- locked  output  1  state is LOCKED

Behaviour:
- Request decode (combinational): req[i] = ~master_fifo_empty[i] & (master_slave_dest[i] == i_am_slave_number).
- State: fsm (IDLE/LOCKED), rr_ptr [$clog2(masters)-1:0], lock_master [$clog2(masters)-1:0].
  - Reset values: IDLE, rr_ptr=0, lock_master=0.
- IDLE:
  - win = first i with req[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo masters.
  - If any req and ~slave_fifo_full: push_to_fifo=1, grant=win, pop_master_vec[win]=1, all in the same cycle (zero latency).
    - If master_last[win]=1: stay IDLE, rr_ptr <= (win+1) mod masters.
    - Else: fsm <= LOCKED, lock_master <= win, rr_ptr unchanged.
  - If no req: push=0, pop=0, grant_master_number=rr_ptr, rr_ptr unchanged.
  - If req but slave_fifo_full: push=0, pop=0, grant_master_number=win, rr_ptr unchanged.
- LOCKED:
  - grant_master_number = lock_master; other masters' requests are ignored.
  - push_to_fifo = req[lock_master] & ~slave_fifo_full.
  - On push with master_last[lock_master]=1: fsm <= IDLE, rr_ptr <= (lock_master+1) mod masters.
  - If the locked master's FIFO is empty, or its head dest is not this slave: push=0, stay LOCKED (the packet bubble is tolerated).
- At most one push per cycle. pop_master_vec is never non-zero while push_to_fifo=0.
- Modulo wrap: rr_ptr at masters-1 wraps to 0, including non-power-of-two masters.
- Reset mid-packet: the lock is dropped, and the next grant is master 0 by priority.
- Reset values of outputs (ARESETn low): push_to_fifo=0, pop_master_vec=0, grant_master_number=0, locked=0.

Optional Feature:
- Macro FORWARD_ARB_STATS_EN.
- When defined, adds output packet_count [0:masters-1], 16 bits each.
  - Increments by 1 on each push where the pushed beat has master_last=1, for the granted master.
  - Saturates at 16'hFFFF.
  - Reset to 0.
- When undefined, the port and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then masters=2, both FIFOs non-empty, dest=0, last=1, full=0 on slave 0 -> grants alternate 0,1,0,1 on consecutive cycles; push=1 every cycle.
- Master 0 sends a 3-beat packet (last on beat 3) while master 1 also requests -> grant=0 for 3 pushes, locked=1 after beat 1 and 0 after beat 3; master 1 is granted the next cycle.
- slave_fifo_full=1 for 2 cycles during a lock -> push=0, pop_master_vec=0, state stays LOCKED; resumes on the same master when full=0.
- Master 1 head dest=1, master 0 dest=0, on the slave 0 instance -> only master 0 is ever granted; master 1 is never popped.
- masters=3, all requesting single-beat packets, rr_ptr=2 -> grant order 2,0,1,2 (wrap check).
- Assert ARESETn low while LOCKED on master 1 -> outputs drop to 0 immediately (async); after release, a first grant with masters 0 and 1 requesting goes to 0. With FORWARD_ARB_STATS_EN, packet_count is 0 after reset and reads 2 after two completed packets.
